// File: rtl/sprite_loader.sv
// sprite_loader: takes pixel bytes over a valid/ready handshake and shifts them
// LSB-first into the sprite shift register, one pixel per permitted cycle.
module sprite_loader #(
    parameter int WIDTH  = 12,
    parameter int HEIGHT = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    input  logic       allow,
    output logic       shiftf,
    output logic       load,
    output logic       data_out,
    output logic       busy,
    output logic       done
);

    localparam int TOTAL = WIDTH * HEIGHT;
    localparam int CW    = $clog2(TOTAL + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BYTE,
        SHIFT,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      buf_q, buf_d;
    logic [3:0]      bit_q, bit_d;
    logic [CW-1:0]   pix_q, pix_d;
    logic            shift_en;
    logic [3:0]      bit_inc;
    logic [CW-1:0]   pix_inc;

    // A shift happens only in SHIFT while the display grants the load window,
    // so the sprite register sees shiftf/load in the same cycle as allow.
    assign shift_en   = (state_q == SHIFT) && allow;
    assign bit_inc    = bit_q + 4'd1;
    assign pix_inc    = pix_q + CW'(1);

    assign shiftf     = shift_en;
    assign load       = shift_en;
    assign data_out   = buf_q[0];
    assign byte_ready = (state_q == WAIT_BYTE);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);

    // State, byte buffer, bit index and pixel counter; reset clears everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            buf_q   <= '0;
            bit_q   <= '0;
            pix_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            bit_q   <= bit_d;
            pix_q   <= pix_d;
        end
    end

    // Next-state logic: the last-pixel check outranks the end-of-byte check,
    // so unused high bits of a partial last byte are simply dropped.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        bit_d   = bit_q;
        pix_d   = pix_q;

        if (shift_en) begin
            buf_d = {1'b0, buf_q[7:1]};
            bit_d = bit_inc;
            pix_d = pix_inc;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT_BYTE;
                    pix_d   = '0;
                    bit_d   = '0;
                end
            end
            WAIT_BYTE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (byte_valid) begin
                    buf_d   = byte_in;
                    bit_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (shift_en) begin
                    if (pix_inc == CW'(TOTAL)) begin
                        state_d = DONE;
                    end else if (bit_inc == 4'd8) begin
                        state_d = WAIT_BYTE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sprite_loader.sv
// tb_sprite_loader: directed checks of sprite_loader (12x12 and a 5x3 instance).
module tb_sprite_loader;

    logic       clk = 1'b0;
    logic       reset;

    logic       start, abort, byte_valid, allow;
    logic [7:0] byte_in;
    logic       byte_ready, shiftf, load, data_out, busy, done;

    logic       p_start, p_abort, p_byte_valid, p_allow;
    logic [7:0] p_byte_in;
    logic       p_byte_ready, p_shiftf, p_load, p_data_out, p_busy, p_done;

    int errors = 0;
    int checks = 0;

    logic [143:0] sr = '0;
    int shift_count = 0;
    int done_count  = 0;
    int p_shift_count = 0;
    int p_zero_count  = 0;

    typedef struct {
        logic allow;
        logic exp_shiftf;
        logic exp_data;
    } vec_t;

    vec_t vecs[13];

    sprite_loader #(.WIDTH(12), .HEIGHT(12)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .allow(allow), .shiftf(shiftf), .load(load), .data_out(data_out),
        .busy(busy), .done(done)
    );

    sprite_loader #(.WIDTH(5), .HEIGHT(3)) dut_small (
        .clk(clk), .reset(reset), .start(p_start), .abort(p_abort),
        .byte_in(p_byte_in), .byte_valid(p_byte_valid), .byte_ready(p_byte_ready),
        .allow(p_allow), .shiftf(p_shiftf), .load(p_load), .data_out(p_data_out),
        .busy(p_busy), .done(p_done)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Behavioural sprite register (MSB-in) plus shift/done tallies, sampled mid-cycle.
    always @(negedge clk) begin
        if (shiftf) begin
            sr          <= {data_out, sr[143:1]};
            shift_count <= shift_count + 1;
        end
        if (done) done_count <= done_count + 1;
        if (p_shiftf) begin
            p_shift_count <= p_shift_count + 1;
            if (!p_data_out) p_zero_count <= p_zero_count + 1;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        allow = v.allow;
    endtask

    // Offer one byte and hold it until the loader takes it (bounded wait).
    task automatic sendByte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        byte_in    = b;
        byte_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (byte_ready) begin
                ok = 1'b1;
                break;
            end
        end
        step();
        byte_valid = 1'b0;
        checkOutput("byte_accepted", int'(ok), 1);
    endtask

    // Full 18-byte upload with bytes 0x00..0x11; optionally pokes start while busy.
    task automatic fullLoad(input bit poke_start);
        int base_shift, base_done, k, done_cyc, busy_after, bad_bits;
        bit accept;
        base_shift = shift_count;
        base_done  = done_count;
        allow = 1'b1;
        start = 1'b1;
        step();
        start      = 1'b0;
        k          = 0;
        byte_in    = 8'h00;
        byte_valid = 1'b1;
        done_cyc   = 0;
        busy_after = 1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            accept = byte_ready && byte_valid;
            if (done && done_cyc == 0) done_cyc = c;
            if (done_cyc != 0 && c == done_cyc + 1) busy_after = int'(busy);
            step();
            if (accept) begin
                k++;
                byte_in = 8'(k);
                if (k == 18) byte_valid = 1'b0;
            end
            start = poke_start && (c == 1 || c == 9);
            if (done_cyc != 0 && c > done_cyc) break;
        end
        start = 1'b0;
        step();
        bad_bits = 0;
        for (int i = 0; i < 144; i++) begin
            if (sr[i] !== logic'(((i / 8) >> (i % 8)) & 1)) bad_bits++;
        end
        checkOutput("full_bytes_taken", k, 18);
        checkOutput("full_done_cycle", done_cyc, 163);
        checkOutput("full_busy_after_done", busy_after, 0);
        checkOutput("full_shift_count", shift_count - base_shift, 144);
        checkOutput("full_done_pulses", done_count - base_done, 1);
        checkOutput("full_sprite_bad_bits", bad_bits, 0);
    endtask

    initial begin
        // allow-gating table for byte 0xA5 (LSB-first 1,0,1,0,0,1,0,1)
        vecs[0]  = '{1'b1, 1'b1, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 1'b1};

        reset = 1'b1;
        start = 1'b0; abort = 1'b0; byte_valid = 1'b0; byte_in = 8'h00; allow = 1'b1;
        p_start = 1'b0; p_abort = 1'b0; p_byte_valid = 1'b0; p_byte_in = 8'h00; p_allow = 1'b1;
        step();
        step();
        @(negedge clk);
        checkOutput("rst_byte_ready", int'(byte_ready), 0);
        checkOutput("rst_shiftf", int'(shiftf), 0);
        checkOutput("rst_load", int'(load), 0);
        checkOutput("rst_data_out", int'(data_out), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        step();
        reset = 1'b0;
        abort = 1'b1;
        step();
        @(negedge clk);
        checkOutput("idle_abort_ignored_busy", int'(busy), 0);
        step();
        abort = 1'b0;

        $display("[TB] full load 12x12");
        fullLoad(1'b0);

        $display("[TB] allow gating");
        start = 1'b1;
        step();
        start = 1'b0;
        sendByte(8'hA5);
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("gate_shiftf_%0d", i), int'(shiftf), int'(vecs[i].exp_shiftf));
            checkOutput($sformatf("gate_load_%0d", i), int'(load), int'(vecs[i].exp_shiftf));
            checkOutput($sformatf("gate_data_%0d", i), int'(data_out), int'(vecs[i].exp_data));
            checkOutput($sformatf("gate_ready_%0d", i), int'(byte_ready), 0);
            step();
        end
        allow = 1'b1;
        @(negedge clk);
        checkOutput("gate_back_to_wait", int'(byte_ready), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        @(negedge clk);
        checkOutput("gate_abort_busy", int'(busy), 0);
        step();

        $display("[TB] abort mid-byte");
        begin
            int base_done;
            base_done = done_count;
            allow = 1'b1;
            start = 1'b1;
            step();
            start = 1'b0;
            sendByte(8'h00);
            sendByte(8'h01);
            sendByte(8'h02);
            step();
            step();
            step();
            abort = 1'b1;
            @(negedge clk);
            checkOutput("abort_cycle_shiftf", int'(shiftf), 1);
            checkOutput("abort_cycle_done", int'(done), 0);
            step();
            abort = 1'b0;
            @(negedge clk);
            checkOutput("abort_busy", int'(busy), 0);
            checkOutput("abort_byte_ready", int'(byte_ready), 0);
            checkOutput("abort_shiftf", int'(shiftf), 0);
            step();
            checkOutput("abort_no_done", done_count - base_done, 0);
        end
        fullLoad(1'b0);

        $display("[TB] synchronous reset mid-upload");
        allow = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        sendByte(8'hFF);
        step();
        step();
        reset = 1'b1;
        step();
        @(negedge clk);
        checkOutput("srst_byte_ready", int'(byte_ready), 0);
        checkOutput("srst_shiftf", int'(shiftf), 0);
        checkOutput("srst_load", int'(load), 0);
        checkOutput("srst_data_out", int'(data_out), 0);
        checkOutput("srst_busy", int'(busy), 0);
        checkOutput("srst_done", int'(done), 0);
        step();
        reset = 1'b0;
        step();

        $display("[TB] start while busy");
        fullLoad(1'b1);

        $display("[TB] partial last byte 5x3");
        begin
            int base_shift, base_zero, pk, p_done_cyc, ready_win;
            bit acc;
            base_shift = p_shift_count;
            base_zero  = p_zero_count;
            p_allow = 1'b1;
            p_start = 1'b1;
            step();
            p_start      = 1'b0;
            pk           = 0;
            p_byte_in    = 8'hFF;
            p_byte_valid = 1'b1;
            p_done_cyc   = 0;
            ready_win    = 0;
            for (int c = 1; c <= 40; c++) begin
                @(negedge clk);
                acc = p_byte_ready && p_byte_valid;
                if (p_byte_ready) ready_win++;
                if (p_done && p_done_cyc == 0) p_done_cyc = c;
                step();
                if (acc) begin
                    pk++;
                    p_byte_in = 8'h7F;
                    if (pk == 2) p_byte_valid = 1'b0;
                end
                if (p_done_cyc != 0) break;
            end
            @(negedge clk);
            checkOutput("part_busy_after_done", int'(p_busy), 0);
            step();
            checkOutput("part_done_cycle", p_done_cyc, 18);
            checkOutput("part_shift_count", p_shift_count - base_shift, 15);
            checkOutput("part_zero_pixels", p_zero_count - base_zero, 0);
            checkOutput("part_ready_windows", ready_win, 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
